// File: rtl/cnn_pkg.sv
// Shared types for the Laplacian convolution back end: pixel type, framer
// states and the beat stored in the output FIFO.
package cnn_pkg;

    localparam int PIXEL_WIDTH      = 8;
    localparam int DEFAULT_ROW_SIZE = 540;
    localparam int CONV_LATENCY     = 2 * DEFAULT_ROW_SIZE + 6;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        STREAM = 2'd2
    } framer_state_e;

    // edge is a reserved word, hence edge_flag
    typedef struct packed {
        logic   sof;
        logic   eol;
        logic   eof;
        logic   edge_flag;
        pixel_t data;
    } edge_beat_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO. The head is read straight from the storage
// flops and forced to zero while empty. A write into a full FIFO succeeds
// when a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // next storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    // state registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/edge_stream_framer.sv
// Framer behind the 3x3 Laplacian: skips the convolution warm-up, drops the
// two row-straddling window positions per row, thresholds kept pixels and
// queues tagged beats for a valid/ready consumer.
//
//  state  | meaning
//  IDLE   | waiting for frame_start
//  WARMUP | convolution pipeline filling, LATENCY-1 clocks
//  STREAM | one conv_pixel per clock, until the eof position
module edge_stream_framer
    import cnn_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int ROW_SIZE   = 540,
    parameter int NUM_ROWS   = 540,
    parameter int LATENCY    = 2 * ROW_SIZE + 6,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [WORD_SIZE-1:0] conv_pixel,
    input  logic [WORD_SIZE-1:0] threshold,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_edge,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic                 busy,
    output logic                 overflow
);

    localparam int WU_W  = $clog2(LATENCY + 1);
    localparam int COL_W = $clog2(ROW_SIZE);
    localparam int ROW_W = $clog2(NUM_ROWS);

    localparam logic [WU_W-1:0]  WU_LOAD  = WU_W'(LATENCY - 2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_SIZE - 1);
    localparam logic [COL_W-1:0] COL_KEEP = COL_W'(ROW_SIZE - 3);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 3);

    framer_state_e        state_q, state_d;
    logic [WU_W-1:0]      wu_cnt_q, wu_cnt_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [WORD_SIZE-1:0] thr_q, thr_d;
    logic                 overflow_q, overflow_d;

    logic       keep;
    logic       at_eof;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    edge_beat_t wr_beat;
    edge_beat_t rd_beat;

    // sequencing: warm-up down-counter, column/row position, keep decision
    always_comb begin
        state_d  = state_q;
        wu_cnt_d = wu_cnt_q;
        col_d    = col_q;
        row_d    = row_q;
        thr_d    = thr_q;
        keep     = 1'b0;
        at_eof   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d  = WARMUP;
                    wu_cnt_d = WU_LOAD;
                    thr_d    = threshold;
                end
            end
            WARMUP: begin
                if (wu_cnt_q == '0) begin
                    state_d = STREAM;
                end else begin
                    wu_cnt_d = wu_cnt_q - 1'b1;
                end
            end
            STREAM: begin
                keep   = (col_q <= COL_KEEP);
                at_eof = (col_q == COL_KEEP) && (row_q == ROW_LAST);
                if (at_eof) begin
                    // trailing drop positions of the last row are not waited for
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // beat assembled at FIFO write; edge uses the threshold latched at frame_start
    always_comb begin
        wr_beat           = '0;
        wr_beat.sof       = (row_q == '0) && (col_q == '0);
        wr_beat.eol       = (col_q == COL_KEEP);
        wr_beat.eof       = at_eof;
        wr_beat.edge_flag = (conv_pixel >= thr_q);
        wr_beat.data      = conv_pixel;
    end

    assign pop = ~fifo_empty & out_ready;

    // sticky overflow: a kept pixel arrived while full with no pop to make room
    always_comb begin
        overflow_d = overflow_q | (keep & fifo_full & ~pop);
    end

    // framer registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wu_cnt_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            thr_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wu_cnt_q   <= wu_cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            thr_q      <= thr_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(edge_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (keep),
        .wr_data (wr_beat),
        .rd_en   (pop),
        .rd_data (rd_beat),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = rd_beat.data;
    assign out_edge  = rd_beat.edge_flag;
    assign out_sof   = rd_beat.sof;
    assign out_eol   = rd_beat.eol;
    assign out_eof   = rd_beat.eof;
    assign busy      = (state_q != IDLE) | ~fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_stream_framer.sv
// Directed bench for edge_stream_framer: 8x6 image, latency 22. dut4 has a
// 4-entry FIFO, dut16 a 16-entry FIFO; both see the same pixel stream.
module tb_edge_stream_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic [7:0] conv_pixel = 8'd0;
    logic [7:0] threshold = 8'd0;
    logic       rdy4 = 1'b0;
    logic       rdy16 = 1'b0;

    logic       v4, edge4, sof4, eol4, eof4, busy4, ovf4;
    logic [7:0] data4;
    logic       v16, edge16, sof16, eol16, eof16, busy16, ovf16;
    logic [7:0] data16;

    wire [11:0] beat4  = {sof4, eol4, eof4, edge4, data4};
    wire [11:0] beat16 = {sof16, eol16, eof16, edge16, data16};

    int checks = 0;
    int passes = 0;
    int n      = 0;
    int mode   = 0;
    int viol   = 0;
    logic [11:0] q4[$];
    logic [11:0] q16[$];

    always #5 clk = ~clk;

    edge_stream_framer #(.WORD_SIZE(8), .ROW_SIZE(8), .NUM_ROWS(6), .LATENCY(22), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .conv_pixel(conv_pixel),
        .threshold(threshold), .out_valid(v4), .out_ready(rdy4), .out_data(data4),
        .out_edge(edge4), .out_sof(sof4), .out_eol(eol4), .out_eof(eof4),
        .busy(busy4), .overflow(ovf4)
    );

    edge_stream_framer #(.WORD_SIZE(8), .ROW_SIZE(8), .NUM_ROWS(6), .LATENCY(22), .FIFO_DEPTH(16)) dut16 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .conv_pixel(conv_pixel),
        .threshold(threshold), .out_valid(v16), .out_ready(rdy16), .out_data(data16),
        .out_edge(edge16), .out_sof(sof16), .out_eol(eol16), .out_eof(eof16),
        .busy(busy16), .overflow(ovf16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // pixel presented at the n-th clock edge after frame_start
    function automatic logic [7:0] pix(input int k);
        if (mode == 0) return 8'(k);
        return (k % 2 == 1) ? 8'd100 : 8'd99;
    endfunction

    // expected beat j of a frame: {sof, eol, eof, edge, data}
    function automatic logic [11:0] exp_beat(input int j, input int thr, input int m);
        int r, c;
        logic [7:0] d;
        r = j / 6;
        c = j % 6;
        if (m == 0) d = 8'(22 + r * 8 + c);
        else        d = (c % 2 == 1) ? 8'd100 : 8'd99;
        return {(j == 0), (c == 5), (j == 23), (32'(d) >= thr), d};
    endfunction

    // record accepted beats, advance one clock, present the next pixel
    task automatic tick();
        if (v4 === 1'b1 && rdy4) q4.push_back(beat4);
        if (v16 === 1'b1 && rdy16) q16.push_back(beat16);
        @(posedge clk);
        #1;
        n++;
        conv_pixel = pix(n);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        n = 0;
        conv_pixel = pix(0);
        tick();
        frame_start = 1'b0;
    endtask

    task automatic run_until(input int last);
        while (n < last) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        q4.delete();
        q16.delete();
    endtask

    task automatic check_frames(input string tag, input logic [11:0] q[$], input int nf,
                                input int thr, input int m);
        check($sformatf("%s_count", tag), q.size(), 24 * nf);
        for (int j = 0; j < q.size() && j < 24 * nf; j++)
            check($sformatf("%s_beat%0d", tag, j), q[j], exp_beat(j % 24, thr, m));
    endtask

    initial begin
        // 1: reset, ramp frame with consumer always ready
        mode = 0;
        threshold = 8'd30;
        rst = 1'b1;
        repeat (3) tick();
        check("reset_out4", {v4, beat4, busy4, ovf4}, 0);
        check("reset_out16", {v16, beat16, busy16, ovf16}, 0);
        rst = 1'b0;
        tick();
        q4.delete();
        q16.delete();
        rdy4 = 1'b1;
        rdy16 = 1'b1;
        start_frame();
        run_until(22);
        check("t1_busy_warmup", busy4, 1);
        check("t1_no_early_valid", v4, 0);
        tick();
        check("t1_first_valid", v4, 1);
        check("t1_first_beat", beat4, exp_beat(0, 30, 0));
        run_until(70);
        check("t1_idle_busy", busy4, 0);
        check_frames("t1_q4", q4, 1, 30, 0);
        check_frames("t1_q16", q16, 1, 30, 0);

        // 2: alternating 99/100 against threshold 100, threshold changed mid-frame
        mode = 1;
        threshold = 8'd100;
        q4.delete();
        q16.delete();
        start_frame();
        run_until(30);
        threshold = 8'd0;
        run_until(70);
        check_frames("t2_q4", q4, 1, 100, 1);
        mode = 0;
        threshold = 8'd30;

        // 3: consumer stalled for the whole frame
        do_reset();
        rdy4 = 1'b0;
        rdy16 = 1'b0;
        start_frame();
        viol = 0;
        while (n < 70) begin
            tick();
            if (n == 26) check("t3_ovf_before", ovf4, 0);
            if (n == 27) check("t3_ovf_after", ovf4, 1);
            if (n >= 23 && (v4 !== 1'b1 || beat4 !== exp_beat(0, 30, 0))) viol++;
        end
        check("t3_head_stable", viol, 0);
        check("t3_head_beat", beat4, exp_beat(0, 30, 0));
        check("t3_busy_held", busy4, 1);
        rdy4 = 1'b1;
        repeat (10) tick();
        check("t3_drained_count", q4.size(), 4);
        for (int j = 0; j < q4.size() && j < 4; j++)
            check($sformatf("t3_drained%0d", j), q4[j], exp_beat(j, 30, 0));
        check("t3_busy_drained", busy4, 0);
        check("t3_ovf_sticky", ovf4, 1);

        // 4: consumer ready every other clock, 16-entry FIFO
        do_reset();
        rdy4 = 1'b1;
        rdy16 = 1'b0;
        start_frame();
        while (n < 110) begin
            rdy16 = ~rdy16;
            tick();
        end
        rdy16 = 1'b0;
        check_frames("t4_q16", q16, 1, 30, 0);
        check("t4_no_overflow", ovf16, 0);

        // 5: reset on the 10th STREAM clock, then a clean frame
        do_reset();
        rdy4 = 1'b0;
        rdy16 = 1'b0;
        start_frame();
        run_until(31);
        check("t5_pre_valid", v4, 1);
        rst = 1'b1;
        tick();
        check("t5_rst_valid4", v4, 0);
        check("t5_rst_busy4", busy4, 0);
        check("t5_rst_busy16", {v16, busy16}, 0);
        rst = 1'b0;
        tick();
        rdy4 = 1'b1;
        rdy16 = 1'b1;
        q4.delete();
        q16.delete();
        start_frame();
        run_until(70);
        check_frames("t5_q4", q4, 1, 30, 0);

        // 6: frame_start ignored mid-STREAM; accepted one clock after eof
        do_reset();
        rdy4 = 1'b1;
        rdy16 = 1'b1;
        start_frame();
        run_until(35);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        run_until(52);
        start_frame();
        run_until(70);
        check_frames("t6_q4", q4, 2, 30, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
